// File: rtl/decode_exec_pipe_reg.sv
// Dual-issue decode->execute pipeline register: turns hazard stalls into NOOP bubbles,
// issues pipe1 late when only it stalls, and handles branch flushes, HALT freeze and stall counting.
module decode_exec_pipe_reg #(
  parameter int DATA_W = 40,
  parameter int ADDR_W = 5,
  parameter int OP_W = 5,
  parameter int CNT_W = 16,
  parameter logic [OP_W-1:0] OP_NOOP = '0,
  parameter logic [OP_W-1:0] OP_HALT = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   opCode0_dec,
  input  logic [OP_W-1:0]   opCode1_dec,
  input  logic [ADDR_W-1:0] addrRd0_dec,
  input  logic [ADDR_W-1:0] addrRd1_dec,
  input  logic [DATA_W-1:0] rm0_in,
  input  logic [DATA_W-1:0] rn0_in,
  input  logic [DATA_W-1:0] ro0_in,
  input  logic [DATA_W-1:0] rm1_in,
  input  logic [DATA_W-1:0] rn1_in,
  input  logic [DATA_W-1:0] ro1_in,
  input  logic              hazardStall0,
  input  logic              hazardStall1,
  input  logic              flush,
  output logic [OP_W-1:0]   opCode0_exe,
  output logic [OP_W-1:0]   opCode1_exe,
  output logic [ADDR_W-1:0] addrRd0_exe,
  output logic [ADDR_W-1:0] addrRd1_exe,
  output logic [DATA_W-1:0] rm0_exe,
  output logic [DATA_W-1:0] rn0_exe,
  output logic [DATA_W-1:0] ro0_exe,
  output logic [DATA_W-1:0] rm1_exe,
  output logic [DATA_W-1:0] rn1_exe,
  output logic [DATA_W-1:0] ro1_exe,
  output logic              stallDecode,
  output logic              halted,
  output logic [CNT_W-1:0]  stallCycles
);

  typedef enum logic [1:0] {RUN, SPLIT, HALTED} state_t;

  localparam logic [ADDR_W-1:0] ADDR_UNUSED = '1;

  state_t state_q, state_d;
  logic halted_q;
  logic [CNT_W-1:0] stallCnt_q;
  logic [OP_W-1:0] op0_q, op1_q;
  logic [ADDR_W-1:0] addr0_q, addr1_q;
  logic [DATA_W-1:0] rm0_q, rn0_q, ro0_q, rm1_q, rn1_q, ro1_q;
  logic issue0, issue1, haltInExe, cntInc;

  assign haltInExe = (op0_q == OP_HALT) || (op1_q == OP_HALT);

  // Stall decision must not look at the *_exe registers, or it would loop through the hazard detector.
  always_comb begin
    stallDecode = 1'b0;
    if (!rst) begin
      unique case (state_q)
        HALTED:  stallDecode = 1'b1;
        SPLIT:   stallDecode = !flush && hazardStall1;
        default: stallDecode = !flush && (hazardStall0 || hazardStall1);
      endcase
    end
  end

  always_comb begin
    issue0 = 1'b0;
    issue1 = 1'b0;
    state_d = state_q;
    if (state_q == HALTED || haltInExe) begin
      state_d = HALTED;
    end else if (flush) begin
      state_d = RUN;
    end else if (state_q == SPLIT) begin
      if (!hazardStall1) begin
        issue1 = 1'b1;
        state_d = RUN;
      end
    end else if (!hazardStall0) begin
      issue0 = 1'b1;
      issue1 = !hazardStall1;
      state_d = hazardStall1 ? SPLIT : RUN;
    end
  end

  assign cntInc = stallDecode && (state_q != HALTED) && (stallCnt_q != '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      halted_q <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      state_q <= state_d;
      halted_q <= (state_d == HALTED);
      if (cntInc) stallCnt_q <= stallCnt_q + 1'b1;
    end
  end

  // Any slot not issued this edge becomes a bubble.
  always_ff @(posedge clk) begin
    if (!rst && issue0) begin
      op0_q <= opCode0_dec;
      addr0_q <= addrRd0_dec;
      rm0_q <= rm0_in;
      rn0_q <= rn0_in;
      ro0_q <= ro0_in;
    end else begin
      op0_q <= OP_NOOP;
      addr0_q <= ADDR_UNUSED;
      rm0_q <= '0;
      rn0_q <= '0;
      ro0_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && issue1) begin
      op1_q <= opCode1_dec;
      addr1_q <= addrRd1_dec;
      rm1_q <= rm1_in;
      rn1_q <= rn1_in;
      ro1_q <= ro1_in;
    end else begin
      op1_q <= OP_NOOP;
      addr1_q <= ADDR_UNUSED;
      rm1_q <= '0;
      rn1_q <= '0;
      ro1_q <= '0;
    end
  end

  assign opCode0_exe = op0_q;
  assign opCode1_exe = op1_q;
  assign addrRd0_exe = addr0_q;
  assign addrRd1_exe = addr1_q;
  assign rm0_exe = rm0_q;
  assign rn0_exe = rn0_q;
  assign ro0_exe = ro0_q;
  assign rm1_exe = rm1_q;
  assign rn1_exe = rn1_q;
  assign ro1_exe = ro1_q;
  assign halted = halted_q;
  assign stallCycles = stallCnt_q;

endmodule

// File: tb/tb_decode_exec_pipe_reg.sv
// Bench for decode_exec_pipe_reg: directed scenarios plus random traffic against a slot-level model.
module tb_decode_exec_pipe_reg;

  localparam logic [4:0] NOOP = 5'd0;
  localparam logic [4:0] HALT = 5'd31;
  localparam logic [4:0] ADD = 5'd1;
  localparam logic [4:0] SUB = 5'd2;
  localparam logic [4:0] LDR = 5'd3;

  typedef struct {
    logic [4:0] op;
    logic [4:0] addr;
    logic [39:0] rm, rn, ro;
  } slot_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] opCode0_dec, opCode1_dec, addrRd0_dec, addrRd1_dec;
  logic [39:0] rm0_in, rn0_in, ro0_in, rm1_in, rn1_in, ro1_in;
  logic hazardStall0, hazardStall1, flush;
  logic [4:0] opCode0_exe, opCode1_exe, addrRd0_exe, addrRd1_exe;
  logic [39:0] rm0_exe, rn0_exe, ro0_exe, rm1_exe, rn1_exe, ro1_exe;
  logic stallDecode, halted;
  logic [15:0] stallCycles;

  int checks = 0;
  int failures = 0;

  slot_t expSlot[2];
  bit mPending;
  bit mHalted;
  logic [15:0] mCnt;
  bit expStall;

  always #5 clk = ~clk;

  decode_exec_pipe_reg #(
    .DATA_W(40), .ADDR_W(5), .OP_W(5), .CNT_W(16), .OP_NOOP(NOOP), .OP_HALT(HALT)
  ) dut (
    .clk(clk), .rst(rst),
    .opCode0_dec(opCode0_dec), .opCode1_dec(opCode1_dec),
    .addrRd0_dec(addrRd0_dec), .addrRd1_dec(addrRd1_dec),
    .rm0_in(rm0_in), .rn0_in(rn0_in), .ro0_in(ro0_in),
    .rm1_in(rm1_in), .rn1_in(rn1_in), .ro1_in(ro1_in),
    .hazardStall0(hazardStall0), .hazardStall1(hazardStall1), .flush(flush),
    .opCode0_exe(opCode0_exe), .opCode1_exe(opCode1_exe),
    .addrRd0_exe(addrRd0_exe), .addrRd1_exe(addrRd1_exe),
    .rm0_exe(rm0_exe), .rn0_exe(rn0_exe), .ro0_exe(ro0_exe),
    .rm1_exe(rm1_exe), .rn1_exe(rn1_exe), .ro1_exe(ro1_exe),
    .stallDecode(stallDecode), .halted(halted), .stallCycles(stallCycles)
  );

  function automatic slot_t bubble();
    slot_t s;
    s.op = NOOP;
    s.addr = 5'd31;
    s.rm = '0;
    s.rn = '0;
    s.ro = '0;
    return s;
  endfunction

  function automatic slot_t decodeSlot(input int p);
    slot_t s;
    s.op = (p == 0) ? opCode0_dec : opCode1_dec;
    s.addr = (p == 0) ? addrRd0_dec : addrRd1_dec;
    s.rm = (p == 0) ? rm0_in : rm1_in;
    s.rn = (p == 0) ? rn0_in : rn1_in;
    s.ro = (p == 0) ? ro0_in : ro1_in;
    return s;
  endfunction

  function automatic logic [39:0] rand40();
    return {$urandom_range(255, 0), $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] op0, input logic [4:0] op1,
                               input logic [4:0] a0, input logic [4:0] a1,
                               input bit hs0, input bit hs1, input bit fl, input bit rs);
    @(negedge clk);
    opCode0_dec = op0;
    opCode1_dec = op1;
    addrRd0_dec = a0;
    addrRd1_dec = a1;
    rm0_in = rand40();
    rn0_in = rand40();
    ro0_in = rand40();
    rm1_in = rand40();
    rn1_in = rand40();
    ro1_in = rand40();
    hazardStall0 = hs0;
    hazardStall1 = hs1;
    flush = fl;
    rst = rs;
  endtask

  task automatic checkOutput();
    chk("op0", 64'(opCode0_exe), 64'(expSlot[0].op));
    chk("addr0", 64'(addrRd0_exe), 64'(expSlot[0].addr));
    chk("rm0", 64'(rm0_exe), 64'(expSlot[0].rm));
    chk("rn0", 64'(rn0_exe), 64'(expSlot[0].rn));
    chk("ro0", 64'(ro0_exe), 64'(expSlot[0].ro));
    chk("op1", 64'(opCode1_exe), 64'(expSlot[1].op));
    chk("addr1", 64'(addrRd1_exe), 64'(expSlot[1].addr));
    chk("rm1", 64'(rm1_exe), 64'(expSlot[1].rm));
    chk("rn1", 64'(rn1_exe), 64'(expSlot[1].rn));
    chk("ro1", 64'(ro1_exe), 64'(expSlot[1].ro));
    chk("halted", 64'(halted), 64'(mHalted));
    chk("stallCycles", 64'(stallCycles), 64'(mCnt));
  endtask

  // Model: SPLIT is "pipe1 of the held bundle still pending"; HALTED freezes everything until reset.
  task automatic stepCycle(input bit doCheck);
    bit haltNow;
    slot_t d0, d1;
    #1;
    if (rst) expStall = 0;
    else if (mHalted) expStall = 1;
    else if (flush) expStall = 0;
    else if (mPending) expStall = hazardStall1;
    else expStall = hazardStall0 || hazardStall1;
    if (doCheck) chk("stallDecode", 64'(stallDecode), 64'(expStall));
    @(posedge clk);
    d0 = decodeSlot(0);
    d1 = decodeSlot(1);
    if (rst) begin
      expSlot[0] = bubble();
      expSlot[1] = bubble();
      mPending = 0;
      mHalted = 0;
      mCnt = 0;
    end else begin
      if (!mHalted && expStall && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
      haltNow = (expSlot[0].op == HALT) || (expSlot[1].op == HALT);
      if (mHalted || haltNow) begin
        expSlot[0] = bubble();
        expSlot[1] = bubble();
        mHalted = 1;
        mPending = 0;
      end else if (flush) begin
        expSlot[0] = bubble();
        expSlot[1] = bubble();
        mPending = 0;
      end else if (mPending) begin
        expSlot[0] = bubble();
        expSlot[1] = hazardStall1 ? bubble() : d1;
        mPending = hazardStall1;
      end else if (hazardStall0) begin
        expSlot[0] = bubble();
        expSlot[1] = bubble();
      end else begin
        expSlot[0] = d0;
        expSlot[1] = hazardStall1 ? bubble() : d1;
        mPending = hazardStall1;
      end
    end
    #1;
    if (doCheck) checkOutput();
  endtask

  initial begin
    logic [4:0] r0, r1;
    expSlot[0] = bubble();
    expSlot[1] = bubble();
    mPending = 0;
    mHalted = 0;
    mCnt = 0;

    applyStimulus(ADD, SUB, 5'd3, 5'd4, 0, 0, 0, 1);
    stepCycle(1);
    applyStimulus(ADD, SUB, 5'd3, 5'd4, 0, 0, 0, 0);
    stepCycle(1);
    chk("plain issue op0", 64'(opCode0_exe), 64'(ADD));
    chk("plain issue addr1", 64'(addrRd1_exe), 64'd4);

    applyStimulus(ADD, SUB, 5'd5, 5'd6, 1, 0, 0, 0);
    stepCycle(1);
    applyStimulus(ADD, SUB, 5'd5, 5'd6, 1, 1, 0, 0);
    stepCycle(1);
    applyStimulus(ADD, SUB, 5'd5, 5'd6, 0, 0, 0, 0);
    stepCycle(1);
    chk("stall0 count", 64'(stallCycles), 64'd2);

    applyStimulus(LDR, ADD, 5'd7, 5'd8, 0, 1, 0, 0);
    stepCycle(1);
    applyStimulus(LDR, ADD, 5'd7, 5'd8, 1, 0, 0, 0);
    stepCycle(1);
    chk("split pipe1 late", 64'(opCode1_exe), 64'(ADD));

    applyStimulus(SUB, LDR, 5'd9, 5'd10, 0, 1, 0, 0);
    stepCycle(1);
    applyStimulus(SUB, LDR, 5'd9, 5'd10, 0, 0, 1, 0);
    stepCycle(1);
    applyStimulus(ADD, ADD, 5'd1, 5'd2, 0, 0, 0, 0);
    stepCycle(1);

    applyStimulus(ADD, HALT, 5'd1, 5'd2, 0, 0, 0, 0);
    stepCycle(1);
    chk("halt in exe", 64'(opCode1_exe), 64'(HALT));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ADD, SUB, 5'd1, 5'd2, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    1'($urandom_range(1, 0)), 0);
      stepCycle(1);
    end
    chk("halted sticky", 64'(halted), 64'd1);
    applyStimulus(ADD, SUB, 5'd1, 5'd2, 0, 0, 0, 1);
    stepCycle(1);

    for (int i = 0; i < 400; i++) begin
      r0 = 5'($urandom_range(30, 0));
      r1 = 5'($urandom_range(30, 0));
      applyStimulus(r0, r1, 5'($urandom), 5'($urandom),
                    $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
                    $urandom_range(9, 0) == 0, $urandom_range(49, 0) == 0);
      stepCycle(1);
    end

    applyStimulus(ADD, SUB, 5'd1, 5'd2, 0, 0, 0, 1);
    stepCycle(1);
    for (int i = 0; i < 65537; i++) begin
      applyStimulus(ADD, SUB, 5'd1, 5'd2, 1, 0, 0, 0);
      stepCycle(0);
    end
    chk("saturated", 64'(stallCycles), 64'hFFFF);
    applyStimulus(ADD, SUB, 5'd1, 5'd2, 1, 1, 0, 0);
    stepCycle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
